aes_encrypt_keygen: RTL and testbench
=====================================

Name: aes_encrypt_keygen

Overview:
AES-128 encryption core with an integrated round-key generator. The block expands a 128-bit cipher key into round keys 0..10 and stores them internally. It then encrypts 128-bit blocks popped from an upstream FIFO, running one AES round per clock. It sits between the input FIFO and the output buffer, and honours back-pressure from the output buffer via is_full.

Parameters:
None. AES-128 only: Nk=4, Nr=10, fixed.

Ports:
clk  in  1  system clock; all state updates on the rising edge
n_rst  in  1  reset; one clock; reset is synchronous and active-high (n_rst=1 at a rising edge resets)
WE_key_generation  in  1  one-cycle pulse: latch input_key and start key expansion
input_key  in  128  cipher key; bits [127:120] = key byte 0
read_fifo  in  1  one-cycle pulse: latch fifo_in and start encryption
fifo_in  in  128  plaintext block; bits [127:120] = state byte 0 (column-major, FIPS-197 order)
is_full  in  1  output buffer full; blocks result delivery
data_output  out  128  ciphertext, same byte order as fifo_in
data_done  out  1  one-cycle pulse when a new ciphertext is written to data_output
data_valid  out  1  high while data_output holds a valid ciphertext
key_ready  out  1  high when round keys 0..10 are all valid

Behaviour:
- Reset: all outputs 0; round-key store cleared; key FSM IDLE; encryption FSM IDLE.
- Key FSM states: IDLE, EXPAND, READY.
  - WE_key_generation=1 in any state: rk0 <= input_key, key_ready <= 0, counter <= 1, go to EXPAND. This restarts an expansion already in progress.
  - EXPAND: one round key per cycle, rk[i] = f(rk[i-1], Rcon[i]) using standard FIPS-197 RotWord/SubWord/Rcon (Rcon 01,02,04,08,10,20,40,80,1b,36).
  - After rk10 is written (10 cycles after the WE edge), key_ready <= 1 and the FSM goes to READY.
- WE_key_generation is ignored while the encryption FSM is not IDLE.
- Encryption FSM states: IDLE, ROUND, HOLD.
  - IDLE with read_fifo=1 and key_ready=1: state <= fifo_in XOR rk0, round <= 1, go to ROUND.
  - read_fifo is ignored if key_ready=0 or the FSM is not IDLE.
  - ROUND: each cycle applies SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[round]). Round 10 omits MixColumns.
  - On completing round 10 with is_full=0: data_output <= result, data_done <= 1 for one cycle, data_valid <= 1, go to IDLE.
  - Latency: data_done is high during the 10th cycle after the edge that sampled read_fifo.
  - On completing round 10 with is_full=1: keep the result internally and go to HOLD. data_output, data_done and data_valid are unchanged.
  - HOLD: on the first cycle with is_full=0, deliver exactly as above and go to IDLE.
- data_valid stays high until the next read_fifo is accepted; acceptance clears it on that same edge. data_output keeps its last value.
- read_fifo and data_done may coincide only after the FSM has returned to IDLE. There is no pipelining: one block in flight.
- Reset mid-expansion or mid-encryption aborts immediately to the reset state; no data_done is produced.
- S-box: a single combinational 256-entry table, instanced for 16 state bytes plus 4 key bytes. GF(2^8) xtime uses polynomial 0x11b.

Test Plan:
- Reset then WE with key 000102030405060708090a0b0c0d0e0f; wait for key_ready; read_fifo with 00112233445566778899aabbccddeeff -> data_done 10 cycles later, data_output = 69c4e0d86a7b0430d8cdb78070b4c55a, data_valid=1.
- Key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready exactly 10 cycles after the WE edge and rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6. Plaintext 3243f6a8885a308d313198a2e0370734 -> data_output = 3925841d02dc09fbdc118597196a0b32.
- read_fifo before key_ready -> ignored: no data_done, data_valid stays 0.
- is_full=1 during round 10 and held for 5 cycles -> no data_done and data_output unchanged. data_done pulses on the first cycle after is_full drops, with the correct ciphertext.
- Back-to-back blocks: 20 blocks from a file-based model, each read_fifo issued after the previous data_done -> every output matches; second read_fifo pulses during ROUND are ignored.
- n_rst=1 at round 5 -> all outputs 0, key_ready=0. A new WE followed by encryption produces correct results.

Source files
------------

// File: rtl/aes_encrypt_keygen.sv
// AES-128 encryption core with an on-chip round-key expander.
// Key expansion and encryption each advance one round per clock; one block in flight.
module aes_encrypt_keygen (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         WE_key_generation,
    input  logic [127:0] input_key,
    input  logic         read_fifo,
    input  logic [127:0] fifo_in,
    input  logic         is_full,
    output logic [127:0] data_output,
    output logic         data_done,
    output logic         data_valid,
    output logic         key_ready
);

    typedef enum logic [1:0] {KEY_IDLE = 2'd0, KEY_EXPAND = 2'd1, KEY_READY = 2'd2} key_state_t;
    typedef enum logic [1:0] {ENC_IDLE = 2'd0, ENC_ROUND = 2'd1, ENC_HOLD = 2'd2} enc_state_t;

    // Byte x of the table sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] temp;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        rot  = {prev[23:0], prev[31:24]};
        temp = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        w0   = prev[127:96] ^ temp;
        w1   = prev[95:64] ^ w0;
        w2   = prev[63:32] ^ w1;
        w3   = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // State byte (row, col) lives at bits [127 - 8*(4*col + row) -: 8].
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = sbox(s[127 - 8*(4*((c + row) % 4) + row) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    key_state_t   key_state_r;
    enc_state_t   enc_state_r;
    logic [127:0] round_key_r [0:10];
    logic [3:0]   key_count_r;
    logic [3:0]   round_r;
    logic [127:0] state_r;
    logic [127:0] next_key_s;
    logic [127:0] shifted_s;
    logic [127:0] round_out_s;

    // Next round key derived from the most recently written one.
    always_comb begin
        next_key_s = expand_key(round_key_r[key_count_r - 4'd1], rcon(key_count_r));
    end

    // One cipher round; the last round skips MixColumns.
    always_comb begin
        shifted_s = sub_shift(state_r);
        if (round_r == 4'd10) begin
            round_out_s = shifted_s ^ round_key_r[round_r];
        end else begin
            round_out_s = mix_columns(shifted_s) ^ round_key_r[round_r];
        end
    end

    // Key FSM: load rk0 on request, then fill rk1..rk10 one per clock.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int i = 0; i <= 10; i++) begin
                round_key_r[i] <= 128'h0;
            end
            key_count_r <= 4'd0;
            key_ready   <= 1'b0;
            key_state_r <= KEY_IDLE;
        end else if (WE_key_generation && (enc_state_r == ENC_IDLE)) begin
            round_key_r[0] <= input_key;
            key_count_r    <= 4'd1;
            key_ready      <= 1'b0;
            key_state_r    <= KEY_EXPAND;
        end else begin
            case (key_state_r)
                KEY_IDLE:  key_state_r <= KEY_IDLE;
                KEY_EXPAND: begin
                    round_key_r[key_count_r] <= next_key_s;
                    key_count_r              <= key_count_r + 4'd1;
                    if (key_count_r == 4'd10) begin
                        key_ready   <= 1'b1;
                        key_state_r <= KEY_READY;
                    end
                end
                KEY_READY: key_state_r <= KEY_READY;
                default:   key_state_r <= KEY_IDLE;
            endcase
        end
    end

    // Encryption FSM: initial AddRoundKey on accept, ten rounds, optional hold on back-pressure.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r     <= 128'h0;
            round_r     <= 4'd0;
            data_output <= 128'h0;
            data_done   <= 1'b0;
            data_valid  <= 1'b0;
            enc_state_r <= ENC_IDLE;
        end else begin
            data_done <= 1'b0;
            case (enc_state_r)
                ENC_IDLE: begin
                    if (read_fifo && key_ready) begin
                        state_r     <= fifo_in ^ round_key_r[0];
                        round_r     <= 4'd1;
                        data_valid  <= 1'b0;
                        enc_state_r <= ENC_ROUND;
                    end
                end
                ENC_ROUND: begin
                    if (round_r != 4'd10) begin
                        state_r <= round_out_s;
                        round_r <= round_r + 4'd1;
                    end else if (is_full) begin
                        state_r     <= round_out_s;
                        enc_state_r <= ENC_HOLD;
                    end else begin
                        data_output <= round_out_s;
                        data_done   <= 1'b1;
                        data_valid  <= 1'b1;
                        enc_state_r <= ENC_IDLE;
                    end
                end
                ENC_HOLD: begin
                    if (!is_full) begin
                        data_output <= state_r;
                        data_done   <= 1'b1;
                        data_valid  <= 1'b1;
                        enc_state_r <= ENC_IDLE;
                    end
                end
                default: enc_state_r <= ENC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_keygen.sv
// Directed bench for aes_encrypt_keygen using FIPS-197 and SP 800-38A ECB vectors.
module tb_aes_encrypt_keygen;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         WE_key_generation = 1'b0;
    logic [127:0] input_key = 128'h0;
    logic         read_fifo = 1'b0;
    logic [127:0] fifo_in = 128'h0;
    logic         is_full = 1'b0;
    logic [127:0] data_output;
    logic         data_done;
    logic         data_valid;
    logic         key_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] pts [5];
    logic [127:0] cts [5];

    always #5 clk = ~clk;

    aes_encrypt_keygen dut (
        .clk(clk),
        .n_rst(n_rst),
        .WE_key_generation(WE_key_generation),
        .input_key(input_key),
        .read_fifo(read_fifo),
        .fifo_in(fifo_in),
        .is_full(is_full),
        .data_output(data_output),
        .data_done(data_done),
        .data_valid(data_valid),
        .key_ready(key_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        tick();
        tick();
        n_rst = 1'b0;
    endtask

    // Pulse WE and count cycles from the WE edge until key_ready (-1 if never).
    task automatic load_key(input logic [127:0] k, output int cyc);
        input_key = k;
        WE_key_generation = 1'b1;
        tick();
        WE_key_generation = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (key_ready) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic pulse_read(input logic [127:0] pt);
        fifo_in = pt;
        read_fifo = 1'b1;
        tick();
        read_fifo = 1'b0;
    endtask

    // Cycles from accept edge to data_done (-1 on timeout); optional spurious read / WE mid-block.
    task automatic wait_done(input bit extra_read, input bit extra_we, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 25; i++) begin
            read_fifo = extra_read && (i == 3);
            if (read_fifo) fifo_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
            WE_key_generation = extra_we && (i == 5);
            if (WE_key_generation) input_key = 128'hffffffffffffffffffffffffffffffff;
            tick();
            read_fifo = 1'b0;
            WE_key_generation = 1'b0;
            if (data_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (data_output !== 128'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", data_output); end
        total++; if (data_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", data_done); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL reset_key_ready got=%b exp=0", key_ready); end
    endtask

    task automatic test_read_before_key();
        bit seen;
        seen = 1'b0;
        pulse_read(128'h00112233445566778899aabbccddeeff);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (data_done || data_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL early_read got=done_or_valid exp=none"); end
    endtask

    task automatic test_fips_c1();
        int cyc;
        load_key(KEY_SEQ, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL c1_key_latency got=%0d exp=10", cyc); end
        pulse_read(128'h00112233445566778899aabbccddeeff);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL c1_valid_cleared got=%b exp=0", data_valid); end
        wait_done(1'b0, 1'b0, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL c1_latency got=%0d exp=10", cyc); end
        total++; if (data_output !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin bad++; $display("FAIL c1_cipher got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", data_output); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL c1_valid got=%b exp=1", data_valid); end
        tick();
        total++; if (data_done !== 1'b0) begin bad++; $display("FAIL c1_done_pulse got=%b exp=0", data_done); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL c1_valid_hold got=%b exp=1", data_valid); end
    endtask

    task automatic test_key_schedule();
        int cyc;
        load_key(KEY_FIPS, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL ks_latency got=%0d exp=10", cyc); end
        total++; if (dut.round_key_r[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL ks_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", dut.round_key_r[10]); end
        pulse_read(128'h3243f6a8885a308d313198a2e0370734);
        wait_done(1'b0, 1'b0, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL ks_enc_latency got=%0d exp=10", cyc); end
        total++; if (data_output !== 128'h3925841d02dc09fbdc118597196a0b32) begin bad++; $display("FAIL ks_cipher got=%h exp=3925841d02dc09fbdc118597196a0b32", data_output); end
    endtask

    task automatic test_full();
        bit early;
        early = 1'b0;
        pulse_read(128'h6bc1bee22e409f96e93d7e117393172a);
        is_full = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (data_done || data_output !== 128'h3925841d02dc09fbdc118597196a0b32 || data_valid) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL full_hold got=delivered exp=held out=%h", data_output); end
        is_full = 1'b0;
        tick();
        total++; if (data_done !== 1'b1) begin bad++; $display("FAIL full_release_done got=%b exp=1", data_done); end
        total++; if (data_output !== 128'h3ad77bb40d7a3660a89ecaf32466ef97) begin bad++; $display("FAIL full_cipher got=%h exp=3ad77bb40d7a3660a89ecaf32466ef97", data_output); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", data_valid); end
        tick();
        total++; if (data_done !== 1'b0) begin bad++; $display("FAIL full_done_pulse got=%b exp=0", data_done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int b = 0; b < 20; b++) begin
            pulse_read(pts[b % 5]);
            wait_done(1'b1, b == 0, cyc);
            total++; if (cyc != 10) begin bad++; $display("FAIL b2b_latency blk=%0d got=%0d exp=10", b, cyc); end
            total++; if (data_output !== cts[b % 5]) begin bad++; $display("FAIL b2b_cipher blk=%0d got=%h exp=%h", b, data_output, cts[b % 5]); end
            total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid blk=%0d got=%b exp=1", b, data_valid); end
        end
        total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL b2b_key_kept got=%b exp=1", key_ready); end
    endtask

    task automatic test_reset_mid();
        int  cyc;
        bit  seen;
        pulse_read(128'h6bc1bee22e409f96e93d7e117393172a);
        for (int i = 0; i < 4; i++) tick();
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        total++; if (data_output !== 128'h0) begin bad++; $display("FAIL mid_reset_out got=%h exp=0", data_output); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", data_valid); end
        total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_key got=%b exp=0", key_ready); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (data_done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_done got=1 exp=0"); end
        load_key(KEY_SEQ, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL mid_reload_latency got=%0d exp=10", cyc); end
        pulse_read(128'h00112233445566778899aabbccddeeff);
        wait_done(1'b0, 1'b0, cyc);
        total++; if (data_output !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin bad++; $display("FAIL mid_reload_cipher got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", data_output); end
    endtask

    task automatic test_zero_key();
        int cyc;
        load_key(128'h0, cyc);
        pulse_read(128'h0);
        wait_done(1'b0, 1'b0, cyc);
        total++; if (data_output !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin bad++; $display("FAIL zero_cipher got=%h exp=66e94bd4ef8a2c3b884cfa59ca342b2e", data_output); end
    endtask

    initial begin
        pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a; cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        pts[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; cts[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        pts[4] = 128'h3243f6a8885a308d313198a2e0370734; cts[4] = 128'h3925841d02dc09fbdc118597196a0b32;
        test_reset();
        test_read_before_key();
        test_fips_c1();
        test_key_schedule();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_zero_key();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
